// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Two-master arbiter and sequencer in front of a single-port RAM that has a
// bidirectional data bus and a registered read. Master 0 is the instruction
// fetch side, master 1 the load/store side. Each master raises req (with
// we/addr/wdata) and holds it until it sees a one-cycle ack. Accesses are
// serialised. A read takes RD1 (RAM registers the word) and RD2 (RAM drives
// the bus) with rdEn held across both. A write takes a single WR cycle during
// which this block drives the bus.
//
// Optional feature (compile-time macro RAM_ARB_RR_EN):
//   defined   - round-robin on a tie, using a 1-bit "last granted" pointer
//               that resets to "master 1 last", so master 0 wins the first tie.
//   undefined - fixed priority, master 1 wins every tie; no pointer exists.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   mN_req/we/addr/wdata       master N request and command (N = 0, 1)
//   mN_ack                     one-cycle completion pulse
//   mN_rdata                   read data, valid with ack, then held
//   ram_addr/ram_rdEn/ram_wrEn RAM control, all registered
//   ram_data                   shared tristate data bus
//   busy                       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int DWIDTH   = 32,
  parameter int MEMDEPTH = 256,
  parameter int AWIDTH   = $clog2(MEMDEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DWIDTH-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_rdEn,
  output logic              ram_wrEn,
  inout  wire  [DWIDTH-1:0] ram_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, WR} state_t;

  state_t              state_reg, state_next;
  logic                sel_reg, sel_next;       // winner: 0 = master 0, 1 = master 1
  logic [DWIDTH-1:0]   wdata_reg, wdata_next;   // latched write data
  logic [AWIDTH-1:0]   addr_reg, addr_next;     // latched address, drives ram_addr
  logic                rd_en_reg, rd_en_next;
  logic                wr_en_reg, wr_en_next;
  logic                ack0_reg, ack0_next;
  logic                ack1_reg, ack1_next;
  logic [DWIDTH-1:0]   rdata0_reg, rdata0_next;
  logic [DWIDTH-1:0]   rdata1_reg, rdata1_next;
  logic                busy_reg, busy_next;

  // A master in its ack cycle is still holding req from the finished access;
  // masking with ack keeps it from being served twice.
  logic elig0, elig1, pick1;
  logic grant_we;

  assign elig0 = m0_req & ~ack0_reg;
  assign elig1 = m1_req & ~ack1_reg;

`ifdef RAM_ARB_RR_EN
  // last_reg = 1 means master 1 was granted last, so master 0 takes a tie.
  logic last_reg, last_next;
  assign pick1 = elig1 & (~elig0 | ~last_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_reg <= 1'b1;
    else        last_reg <= last_next;
  end
`else
  assign pick1 = elig1;
`endif

  assign grant_we = pick1 ? m1_we : m0_we;

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    wdata_next  = wdata_reg;
    addr_next   = addr_reg;
    rd_en_next  = 1'b0;
    wr_en_next  = 1'b0;
    ack0_next   = 1'b0;
    ack1_next   = 1'b0;
    rdata0_next = rdata0_reg;
    rdata1_next = rdata1_reg;
`ifdef RAM_ARB_RR_EN
    last_next   = last_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (elig0 | elig1) begin
          sel_next   = pick1;
          addr_next  = pick1 ? m1_addr  : m0_addr;
          wdata_next = pick1 ? m1_wdata : m0_wdata;
          // Enables are registered, so they are raised here to be live
          // during the first cycle of the access.
          rd_en_next = ~grant_we;
          wr_en_next = grant_we;
          state_next = grant_we ? WR : RD1;
`ifdef RAM_ARB_RR_EN
          last_next  = pick1;
`endif
        end
      end
      RD1: begin
        rd_en_next = 1'b1;          // held through the bus-drive cycle
        state_next = RD2;
      end
      RD2: begin
        // The RAM drives the bus during RD2; capture it at the closing edge.
        if (sel_reg) begin
          rdata1_next = ram_data;
          ack1_next   = 1'b1;
        end else begin
          rdata0_next = ram_data;
          ack0_next   = 1'b1;
        end
        state_next = IDLE;
      end
      WR: begin
        if (sel_reg) ack1_next = 1'b1;
        else         ack0_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sel_reg    <= 1'b0;
      wdata_reg  <= '0;
      addr_reg   <= '0;
      rd_en_reg  <= 1'b0;
      wr_en_reg  <= 1'b0;
      ack0_reg   <= 1'b0;
      ack1_reg   <= 1'b0;
      rdata0_reg <= '0;
      rdata1_reg <= '0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      wdata_reg  <= wdata_next;
      addr_reg   <= addr_next;
      rd_en_reg  <= rd_en_next;
      wr_en_reg  <= wr_en_next;
      ack0_reg   <= ack0_next;
      ack1_reg   <= ack1_next;
      rdata0_reg <= rdata0_next;
      rdata1_reg <= rdata1_next;
      busy_reg   <= busy_next;
    end
  end

  // Bus is driven only while the registered write enable is high, i.e. in WR.
  assign ram_data = wr_en_reg ? wdata_reg : {DWIDTH{1'bz}};

  assign ram_addr = addr_reg;
  assign ram_rdEn = rd_en_reg;
  assign ram_wrEn = wr_en_reg;
  assign m0_ack   = ack0_reg;
  assign m1_ack   = ack1_reg;
  assign m0_rdata = rdata0_reg;
  assign m1_rdata = rdata1_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Bench for ram_arbiter. Contains a model of the single-port RAM (registered
// read, drives the bus in the cycle after the read is registered while rdEn
// is still high). Whenever neither the RAM nor a write should be on the bus,
// the bench holds the bus at zero so a stray drive from the arbiter shows up
// as a non-zero value. Expected read data comes from a shadow memory and is
// queued per master when a request is issued, then popped on each ack.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [7:0]  ram_addr;
  logic        ram_rdEn, ram_wrEn, busy;
  wire  [31:0] ram_data;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_rdEn(ram_rdEn), .ram_wrEn(ram_wrEn),
    .ram_data(ram_data), .busy(busy)
  );

  // RAM model
  logic [31:0] mem [0:255];
  logic [31:0] rd_reg;
  logic        drive_q;
  wire         ram_drv = ram_rdEn & drive_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_q <= 1'b0;
    end else begin
      drive_q <= ram_rdEn & ~drive_q;
      if (ram_rdEn) rd_reg <= mem[ram_addr];
      if (ram_wrEn) mem[ram_addr] <= ram_data;
    end
  end

  assign ram_data = ram_wrEn ? 32'bz : (ram_drv ? rd_reg : 32'h0);

  // Scoreboard state
  typedef struct {
    bit          we;
    logic [31:0] data;
  } sb_t;

  sb_t         q0[$];
  sb_t         q1[$];
  logic [31:0] shadow [0:255];
  bit          written [0:255];
  logic [31:0] hold0 = 32'h0;
  logic [31:0] hold1 = 32'h0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Per-cycle checks, sampled on the falling edge.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      hold0 = 32'h0;
      hold1 = 32'h0;
      q0.delete();
      q1.delete();
    end
    check_value("rw_excl", 64'(ram_rdEn & ram_wrEn), 64'd0);
    check_value("busy", 64'(busy), 64'(ram_rdEn | ram_wrEn));
    if (ram_wrEn)     check_value("wr_data", 64'(ram_data), 64'(shadow[ram_addr]));
    else if (ram_drv) check_value("bus_rd", 64'(ram_data), 64'(rd_reg));
    else              check_value("bus_idle", 64'(ram_data), 64'd0);
    if (m0_ack) begin
      if (q0.size() == 0) check_value("m0_spurious_ack", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        if (!e.we) begin
          hold0 = e.data;
          check_value("m0_rdata", 64'(m0_rdata), 64'(e.data));
        end
      end
    end
    if (m1_ack) begin
      if (q1.size() == 0) check_value("m1_spurious_ack", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        if (!e.we) begin
          hold1 = e.data;
          check_value("m1_rdata", 64'(m1_rdata), 64'(e.data));
        end
      end
    end
    check_value("m0_hold", 64'(m0_rdata), 64'(hold0));
    check_value("m1_hold", 64'(m1_rdata), 64'(hold1));
    $display("cyc rdEn=%0b wrEn=%0b addr=%0h bus=%0h ack0=%0b ack1=%0b", ram_rdEn, ram_wrEn, ram_addr, ram_data, m0_ack, m1_ack);
  end

  // Issue one access; called on a falling edge, returns on the falling edge
  // where ack is seen. lat = number of cycles from request to ack.
  task automatic do_access(input int m, input bit we, input logic [7:0] addr,
                           input logic [31:0] wdata, input bit keep, output int lat);
    sb_t e;
    bit  got;
    e.we   = we;
    e.data = we ? wdata : shadow[addr];
    if (we) begin
      shadow[addr]  = wdata;
      written[addr] = 1'b1;
    end
    if (m == 0) begin
      q0.push_back(e);
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      q1.push_back(e);
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      got = (m == 0) ? m0_ack : m1_ack;
    end
    if (!got) check_value("ack_timeout", 64'd0, 64'd1);
    if (!keep || !got) begin
      if (m == 0) m0_req = 1'b0;
      else        m1_req = 1'b0;
    end
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_random(input int m);
    int          lat;
    bit          we;
    logic [7:0]  addr;
    repeat (150) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      we   = 1'($urandom_range(0, 1));
      addr = (m == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
      if (!we && !written[addr]) we = 1'b1;
      do_access(m, we, addr, $urandom, 1'b0, lat);
    end
  endtask

  initial begin
    int lat, l0, l1;
    bit exp_w;
`ifdef RAM_ARB_RR_EN
    bit rr_last;
`endif
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h0; m1_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    check_value("rst_rdEn", 64'(ram_rdEn), 64'd0);
    check_value("rst_wrEn", 64'(ram_wrEn), 64'd0);
    check_value("rst_addr", 64'(ram_addr), 64'd0);
    check_value("rst_ack0", 64'(m0_ack), 64'd0);
    check_value("rst_ack1", 64'(m1_ack), 64'd0);
    check_value("rst_rdata0", 64'(m0_rdata), 64'd0);
    check_value("rst_rdata1", 64'(m1_rdata), 64'd0);
    check_value("rst_busy", 64'(busy), 64'd0);

    // m1 write, then m0 read of the same word
    do_access(1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, lat);
    check_value("wr_lat", 64'(lat), 64'd2);
    @(negedge clk);
    do_access(0, 1'b0, 8'h10, 32'h0, 1'b0, lat);
    check_value("rd_lat", 64'(lat), 64'd3);
    check_value("rd_m1_rdata_held", 64'(m1_rdata), 64'd0);
    @(negedge clk);

    // m1 re-requests in its own ack cycle
    do_access(1, 1'b1, 8'h20, 32'h11112222, 1'b1, lat);
    check_value("b2b_first_lat", 64'(lat), 64'd2);
    do_access(1, 1'b1, 8'h20, 32'hCAFEF00D, 1'b0, lat);
    check_value("b2b_second_lat", 64'(lat), 64'd3);
    @(negedge clk);
    do_access(0, 1'b0, 8'h20, 32'h0, 1'b0, lat);
    check_value("b2b_readback_lat", 64'(lat), 64'd3);
    @(negedge clk);

    // Reset during RD2 aborts the read with no ack
    m0_we = 1'b0; m0_addr = 8'h10; m0_req = 1'b1;
    @(negedge clk);
    check_value("abort_rd1_rdEn", 64'(ram_rdEn), 64'd1);
    @(negedge clk);
    check_value("abort_rd2_rdEn", 64'(ram_rdEn), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_value("abort_rdEn", 64'(ram_rdEn), 64'd0);
    check_value("abort_busy", 64'(busy), 64'd0);
    check_value("abort_bus_released", 64'(ram_data), 64'd0);
    check_value("abort_ack", 64'(m0_ack), 64'd0);
    m0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(0, 1'b0, 8'h10, 32'h0, 1'b0, lat);
    check_value("post_reset_rd_lat", 64'(lat), 64'd3);
    @(negedge clk);

    // Ties: both masters request reads in the same cycle
    apply_reset();
`ifdef RAM_ARB_RR_EN
    rr_last = 1'b1;
`endif
    for (int t = 0; t < 4; t++) begin
`ifdef RAM_ARB_RR_EN
      exp_w = ~rr_last;
`else
      exp_w = 1'b1;
`endif
      fork
        do_access(0, 1'b0, 8'h10, 32'h0, 1'b0, l0);
        do_access(1, 1'b0, 8'h20, 32'h0, 1'b0, l1);
      join
      check_value("tie_m0_lat", 64'(l0), exp_w ? 64'd6 : 64'd3);
      check_value("tie_m1_lat", 64'(l1), exp_w ? 64'd3 : 64'd6);
`ifdef RAM_ARB_RR_EN
      rr_last = ~exp_w;
`endif
      @(negedge clk);
    end

    // Random mix from both masters on disjoint address halves
    fork
      run_random(0);
      run_random(1);
    join
    repeat (10) @(negedge clk);
    check_value("q0_drained", 64'(q0.size()), 64'd0);
    check_value("q1_drained", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
